// File: rtl/addr_rf_expander.sv
// addr_rf_expander: expands a stream of (h,w) coordinates into NCH register-file
// entries {k, h+r*s, w} per sample, written at per-channel base pointers + sample index.
// Build option: define ADDR_RF_CLAMP_EN for a saturating h field; otherwise h wraps mod 2^CW.
module addr_rf_expander #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned DEPTH = 10,
    parameter int unsigned CW    = 7,
    parameter int unsigned KW    = 5,
    parameter int unsigned RW    = 3,
    parameter int unsigned PW    = 11,
    parameter int unsigned LW    = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_start,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [CW-1:0]                    i_h,
    input  logic [CW-1:0]                    i_w,
    input  logic [NCH-1:0][RW-1:0]           i_r,
    input  logic [NCH-1:0][KW-1:0]           i_k,
    input  logic [NCH-1:0][PW-1:0]           i_ptr,
    input  logic [RW-1:0]                    i_s,
    input  logic [LW-1:0]                    i_length,
    output logic                             o_busy,
    output logic                             o_finish,
    output logic                             o_ovf,
    output logic [DEPTH-1:0][2:0][CW-1:0]    o_RF
);

    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned AW  = PW + LW;
    localparam int unsigned PRW = 2 * RW;
`ifdef ADDR_RF_CLAMP_EN
    localparam int unsigned SW  = CW + PRW;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_RECV   = 3'd2,
        S_EXPAND = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic                   ready_d;
    logic                   busy_d;
    logic                   finish_d;

    logic [NCH-1:0][RW-1:0] r_q;
    logic [NCH-1:0][KW-1:0] k_q;
    logic [NCH-1:0][PW-1:0] ptr_q;
    logic [RW-1:0]          s_q;
    logic [LW-1:0]          len_q;
    logic [LW-1:0]          idx_q;
    logic [CHW-1:0]         ch_q;
    logic [CW-1:0]          h_q;
    logic [CW-1:0]          w_q;

    logic [AW-1:0]          addr_c;
    logic                   in_range_c;
    logic [PRW-1:0]         prod_c;
    logic [CW-1:0]          h_field_c;
`ifdef ADDR_RF_CLAMP_EN
    logic [SW-1:0]          sum_c;
`endif

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; output targets are derived from the next state so the
    // registered outputs line up with the state they describe
    always_comb begin
        state_d  = state_q;
        ready_d  = 1'b0;
        busy_d   = 1'b0;
        finish_d = 1'b0;
        unique case (state_q)
            S_IDLE:   if (i_start) state_d = S_CLEAR;
            S_CLEAR:  state_d = (len_q != '0) ? S_RECV : S_DONE;
            S_RECV:   if (i_valid && o_ready) state_d = S_EXPAND;
            S_EXPAND: begin
                if (ch_q == CHW'(NCH - 1)) begin
                    state_d = ((idx_q + LW'(1)) == len_q) ? S_DONE : S_RECV;
                end
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        ready_d  = (state_d == S_RECV);
        busy_d   = (state_d != S_IDLE);
        finish_d = (state_d == S_DONE);
    end

    // Target address (full PW+LW width, never truncated) and h-field arithmetic
    always_comb begin
        addr_c     = AW'(ptr_q[ch_q]) + AW'(idx_q);
        in_range_c = (addr_c < AW'(DEPTH));
        prod_c     = PRW'(r_q[ch_q]) * PRW'(s_q);
`ifdef ADDR_RF_CLAMP_EN
        sum_c      = SW'(h_q) + SW'(prod_c);
        h_field_c  = (|sum_c[SW-1:CW]) ? '1 : sum_c[CW-1:0];
`else
        h_field_c  = h_q + CW'(prod_c);
`endif
    end

    // Config capture, sample latch, channel/index counters, RF writes and outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ready  <= 1'b0;
            o_busy   <= 1'b0;
            o_finish <= 1'b0;
            o_ovf    <= 1'b0;
            o_RF     <= '0;
            r_q      <= '0;
            k_q      <= '0;
            ptr_q    <= '0;
            s_q      <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            ch_q     <= '0;
            h_q      <= '0;
            w_q      <= '0;
        end else begin
            o_ready  <= ready_d;
            o_busy   <= busy_d;
            o_finish <= finish_d;
            unique case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        r_q   <= i_r;
                        k_q   <= i_k;
                        ptr_q <= i_ptr;
                        s_q   <= i_s;
                        len_q <= i_length;
                    end
                end
                S_CLEAR: begin
                    o_RF  <= '0;
                    o_ovf <= 1'b0;
                    idx_q <= '0;
                    ch_q  <= '0;
                end
                S_RECV: begin
                    if (i_valid && o_ready) begin
                        h_q  <= i_h;
                        w_q  <= i_w;
                        ch_q <= '0;
                    end
                end
                S_EXPAND: begin
                    if (in_range_c) begin
                        for (int unsigned i = 0; i < DEPTH; i++) begin
                            if (addr_c == AW'(i)) begin
                                o_RF[i] <= {CW'(k_q[ch_q]), h_field_c, w_q};
                            end
                        end
                    end else begin
                        o_ovf <= 1'b1;
                    end
                    if (ch_q == CHW'(NCH - 1)) begin
                        ch_q  <= '0;
                        idx_q <= idx_q + LW'(1);
                    end else begin
                        ch_q  <= ch_q + CHW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_addr_rf_expander.sv
// Bench for addr_rf_expander: directed scenarios plus randomized runs checked
// against a whole-run model of the register file built from the expansion rule.
module tb_addr_rf_expander;

    localparam int NCH   = 4;
    localparam int DEPTH = 10;
    localparam int CW    = 7;
    localparam int KW    = 5;
    localparam int RW    = 3;
    localparam int PW    = 11;
    localparam int LW    = 4;

    logic                          i_clk = 1'b0;
    logic                          i_rst = 1'b1;
    logic                          i_start = 1'b0;
    logic                          i_valid = 1'b0;
    logic                          o_ready;
    logic [CW-1:0]                 i_h = '0;
    logic [CW-1:0]                 i_w = '0;
    logic [NCH-1:0][RW-1:0]        i_r = '0;
    logic [NCH-1:0][KW-1:0]        i_k = '0;
    logic [NCH-1:0][PW-1:0]        i_ptr = '0;
    logic [RW-1:0]                 i_s = '0;
    logic [LW-1:0]                 i_length = '0;
    logic                          o_busy;
    logic                          o_finish;
    logic                          o_ovf;
    logic [DEPTH-1:0][2:0][CW-1:0] o_RF;

    int checks = 0;
    int errors = 0;

    int cfg_r[NCH];
    int cfg_k[NCH];
    int cfg_ptr[NCH];
    int cfg_s;
    int smp_h[16];
    int smp_w[16];

    int mk[DEPTH];
    int mh[DEPTH];
    int mw[DEPTH];
    bit movf;

    always #5 i_clk = ~i_clk;

    addr_rf_expander #(
        .NCH(NCH), .DEPTH(DEPTH), .CW(CW), .KW(KW), .RW(RW), .PW(PW), .LW(LW)
    ) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (i_start),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_h      (i_h),
        .i_w      (i_w),
        .i_r      (i_r),
        .i_k      (i_k),
        .i_ptr    (i_ptr),
        .i_s      (i_s),
        .i_length (i_length),
        .o_busy   (o_busy),
        .o_finish (o_finish),
        .o_ovf    (o_ovf),
        .o_RF     (o_RF)
    );

    // Expected h field from plain integer arithmetic
    function automatic int exp_h(input int h, input int r, input int s);
        int v;
        v = h + r * s;
`ifdef ADDR_RF_CLAMP_EN
        return (v > (1 << CW) - 1) ? (1 << CW) - 1 : v;
`else
        return v % (1 << CW);
`endif
    endfunction

    // Final register-file contents of a whole run: later channel / later sample wins
    task automatic build_model(input int len);
        int a;
        movf = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mk[i] = 0; mh[i] = 0; mw[i] = 0;
        end
        for (int n = 0; n < len; n++) begin
            for (int c = 0; c < NCH; c++) begin
                a = cfg_ptr[c] + n;
                if (a < DEPTH) begin
                    mk[a] = cfg_k[c];
                    mh[a] = exp_h(smp_h[n], cfg_r[c], cfg_s);
                    mw[a] = smp_w[n];
                end else begin
                    movf = 1'b1;
                end
            end
        end
    endtask

    task automatic drive_cfg();
        for (int c = 0; c < NCH; c++) begin
            i_r[c]   = RW'(cfg_r[c]);
            i_k[c]   = KW'(cfg_k[c]);
            i_ptr[c] = PW'(cfg_ptr[c]);
        end
        i_s = RW'(cfg_s);
    endtask

    task automatic scramble_cfg();
        for (int c = 0; c < NCH; c++) begin
            i_r[c]   = RW'($urandom);
            i_k[c]   = KW'($urandom);
            i_ptr[c] = PW'($urandom);
        end
        i_s      = RW'($urandom);
        i_length = LW'($urandom);
    endtask

    task automatic set_test_cfg();
        cfg_r   = '{0, 1, 2, 3};
        cfg_k   = '{0, 0, 0, 1};
        cfg_ptr = '{0, 3, 5, 8};
        cfg_s   = 1;
    endtask

    // One complete run: start, feed samples, wait for finish, compare timing and RF
    task automatic run_case(input string name, input int len, input bit gaps, input bit start_in_recv);
        int sent, cyc, fin_cnt, fin_cyc, last_acc, prev_acc, first_acc, ready_hi, bad_gap, exp_fin, exp_rh, si;
        bit acc, pulsed;
        logic [2:0][CW-1:0] e;
        sent = 0; cyc = 0; fin_cnt = 0; fin_cyc = -1; last_acc = -1; prev_acc = -1;
        first_acc = -1; ready_hi = 0; bad_gap = 0; pulsed = 1'b0;
        build_model(len);
        @(negedge i_clk);
        drive_cfg();
        i_length = LW'(len);
        i_start  = 1'b1;
        i_valid  = 1'b0;
        @(posedge i_clk);
        while (fin_cnt == 0 && cyc < 400) begin
            @(negedge i_clk);
            cyc++;
            i_start = 1'b0;
            if (cyc == 1) begin
                scramble_cfg();
                checks++;
                if (o_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_after_start: got %b expected 1", name, o_busy);
                end
            end
            if (o_finish === 1'b1) begin
                fin_cnt++;
                fin_cyc = cyc;
            end
            if (o_ready === 1'b1) ready_hi++;
            if (start_in_recv && !pulsed && sent == 1 && o_ready === 1'b1) begin
                i_start = 1'b1;
                pulsed  = 1'b1;
                i_valid = 1'b0;
            end else begin
                i_valid = (sent < len) && (!gaps || $urandom_range(0, 2) != 0);
                si = (sent < 16) ? sent : 15;
                i_h = CW'(smp_h[si]);
                i_w = CW'(smp_w[si]);
            end
            acc = (o_ready === 1'b1) && i_valid;
            if (acc) begin
                if (prev_acc >= 0 && (cyc - prev_acc) != NCH + 1) bad_gap++;
                if (first_acc < 0) first_acc = cyc;
                prev_acc = cyc;
                last_acc = cyc;
                sent++;
            end
            @(posedge i_clk);
        end
        i_valid = 1'b0;
        i_start = 1'b0;

        checks++;
        if (fin_cnt != 1) begin
            errors++;
            $display("FAIL %s finish_seen: got %0d pulses expected 1 (cycle budget expired)", name, fin_cnt);
        end
        exp_fin = (len == 0) ? 2 : last_acc + NCH + 1;
        checks++;
        if (fin_cyc != exp_fin) begin
            errors++;
            $display("FAIL %s finish_cycle: got %0d expected %0d", name, fin_cyc, exp_fin);
        end
        checks++;
        if (sent != len) begin
            errors++;
            $display("FAIL %s samples_accepted: got %0d expected %0d", name, sent, len);
        end
        if (!gaps) begin
            exp_rh = len + (start_in_recv ? 1 : 0);
            checks++;
            if (ready_hi != exp_rh) begin
                errors++;
                $display("FAIL %s ready_high_cycles: got %0d expected %0d", name, ready_hi, exp_rh);
            end
            if (len > 0) begin
                checks++;
                if (first_acc != 2) begin
                    errors++;
                    $display("FAIL %s first_accept_cycle: got %0d expected 2", name, first_acc);
                end
            end
            if (len > 1 && !start_in_recv) begin
                checks++;
                if (bad_gap != 0) begin
                    errors++;
                    $display("FAIL %s sample_spacing: got %0d bad gaps expected 0", name, bad_gap);
                end
            end
        end

        @(negedge i_clk);
        checks++;
        if (o_finish !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s after_finish: got fin=%b busy=%b ready=%b expected 0 0 0",
                     name, o_finish, o_busy, o_ready);
        end
        for (int i = 0; i < DEPTH; i++) begin
            e[2] = CW'(mk[i]);
            e[1] = CW'(mh[i]);
            e[0] = CW'(mw[i]);
            checks++;
            if (o_RF[i] !== e) begin
                errors++;
                $display("FAIL %s RF[%0d]: got k=%0d h=%0d w=%0d expected k=%0d h=%0d w=%0d",
                         name, i, o_RF[i][2], o_RF[i][1], o_RF[i][0], e[2], e[1], e[0]);
            end
        end
        checks++;
        if (o_ovf !== movf) begin
            errors++;
            $display("FAIL %s ovf: got %b expected %b", name, o_ovf, movf);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        checks++;
        if (o_ready !== 1'b0 || o_busy !== 1'b0 || o_finish !== 1'b0 || o_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got ready=%b busy=%b fin=%b ovf=%b expected 0 0 0 0",
                     o_ready, o_busy, o_finish, o_ovf);
        end
        checks++;
        if (o_RF !== '0) begin
            errors++;
            $display("FAIL reset_rf: got %h expected 0", o_RF);
        end
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b ready=%b expected 0 0", o_busy, o_ready);
        end
    endtask

    task automatic test_single();
        logic [2:0][CW-1:0] e;
        set_test_cfg();
        smp_h[0] = 10; smp_w[0] = 11;
        run_case("single", 1, 1'b0, 1'b0);
        e[2] = 7'd1; e[1] = 7'd13; e[0] = 7'd11;
        checks++;
        if (o_RF[8] !== e) begin
            errors++;
            $display("FAIL single_rf8: got %h expected %h", o_RF[8], e);
        end
    endtask

    task automatic test_back_to_back();
        set_test_cfg();
        smp_h[0] = 10; smp_w[0] = 11;
        smp_h[1] = 11; smp_w[1] = 10;
        run_case("back_to_back", 2, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        set_test_cfg();
        smp_h[0] = 10; smp_w[0] = 11;
        smp_h[1] = 11; smp_w[1] = 10;
        smp_h[2] = 12; smp_w[2] = 13;
        run_case("overflow", 3, 1'b0, 1'b0);
        checks++;
        if (o_ovf !== 1'b1) begin
            errors++;
            $display("FAIL overflow_flag: got %b expected 1", o_ovf);
        end
        run_case("overflow_restart", 1, 1'b0, 1'b0);
    endtask

    task automatic test_h_field();
        int want;
        set_test_cfg();
        smp_h[0] = 126; smp_w[0] = 5;
`ifdef ADDR_RF_CLAMP_EN
        want = 127;
`else
        want = 1;
`endif
        run_case("h_field", 1, 1'b0, 1'b0);
        checks++;
        if (o_RF[8][1] !== CW'(want)) begin
            errors++;
            $display("FAIL h_field_rf8: got %0d expected %0d", o_RF[8][1], want);
        end
    endtask

    task automatic test_zero_length();
        set_test_cfg();
        run_case("zero_length", 0, 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored();
        set_test_cfg();
        smp_h[0] = 20; smp_w[0] = 21;
        smp_h[1] = 30; smp_w[1] = 31;
        run_case("start_in_recv", 2, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_run();
        logic [2:0][CW-1:0] e;
        int waited;
        set_test_cfg();
        @(negedge i_clk);
        drive_cfg();
        i_length = LW'(2);
        i_start  = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        waited = 0;
        while (o_ready !== 1'b1 && waited < 20) begin
            @(negedge i_clk);
            waited++;
        end
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_wait_ready: got %b expected 1 (cycle budget expired)", o_ready);
        end
        i_valid = 1'b1;
        i_h = 7'd10;
        i_w = 7'd11;
        @(negedge i_clk);
        i_valid = 1'b0;
        checks++;
        if (o_RF[0] !== '0) begin
            errors++;
            $display("FAIL rst_mid_ch0_early: got %h expected 0", o_RF[0]);
        end
        @(negedge i_clk);
        e[2] = 7'd0; e[1] = 7'd10; e[0] = 7'd11;
        checks++;
        if (o_RF[0] !== e) begin
            errors++;
            $display("FAIL rst_mid_ch0_written: got %h expected %h", o_RF[0], e);
        end
        #1 i_rst = 1'b1;
        #1;
        checks++;
        if (o_RF !== '0 || o_ready !== 1'b0 || o_busy !== 1'b0 || o_finish !== 1'b0 || o_ovf !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async: got rf_nonzero=%b ready=%b busy=%b fin=%b ovf=%b expected all 0",
                     (o_RF != '0), o_ready, o_busy, o_finish, o_ovf);
        end
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_random();
        int len;
        bit gaps;
        for (int it = 0; it < 25; it++) begin
            for (int c = 0; c < NCH; c++) begin
                cfg_r[c]   = $urandom_range(0, 7);
                cfg_k[c]   = $urandom_range(0, 31);
                cfg_ptr[c] = ($urandom_range(0, 5) == 0) ? 2047 - $urandom_range(0, 3)
                                                         : $urandom_range(0, 12);
            end
            cfg_s = $urandom_range(0, 7);
            for (int n = 0; n < 16; n++) begin
                smp_h[n] = $urandom_range(0, 127);
                smp_w[n] = $urandom_range(0, 127);
            end
            len  = $urandom_range(0, 6);
            gaps = 1'($urandom_range(0, 1));
            run_case("random", len, gaps, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_h_field();
        test_zero_length();
        test_start_ignored();
        test_reset_mid_run();
        test_single();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
